// File: rtl/acc_seq_ctrl.sv
// APB-programmed sequencer that issues indexed ops to an accelerator datapath.
// Bounds ops in flight, counts in-order completions, and raises a done interrupt.
module acc_seq_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int MAX_OUTST      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      acc_req_o,
    output logic [7:0]                acc_idx_o,
    input  logic                      acc_gnt_i,
    input  logic                      acc_rvalid_i,
    output logic                      irq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [3:0] MaxOutst = 4'(MAX_OUTST);
    localparam logic [1:0] RegCtrl  = 2'd0;
    localparam logic [1:0] RegCfg   = 2'd1;
    localparam logic [1:0] RegStat  = 2'd2;
    localparam logic [1:0] RegCount = 2'd3;

    state_e     state_q, state_d;
    logic [7:0] base_q, base_d;
    logic [8:0] len_q, len_d;
    logic       irq_en_q, irq_en_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       abort_q, abort_d;
    logic [8:0] count_q, count_d;
    logic [8:0] issued_q, issued_d;
    logic [3:0] outst_q, outst_d;

    logic       apb_acc;
    logic       addr_bad;
    logic [1:0] reg_sel;
    logic       wr_ok;
    logic       rd_ok;
    logic       start_wr;
    logic       abort_wr;
    logic       busy;
    logic       grant;
    logic       rv_ok;
    logic       rv_bad;
    logic       len_ok;
    logic       done_set;
    logic       done_clr;
    logic       err_set;
    logic       err_clr;
    logic       launch;
    logic       unused_pwdata;

    assign unused_pwdata = ^PWDATA[30:17];

    assign apb_acc  = PSEL & PENABLE;
    assign addr_bad = (|PADDR[APB_ADDR_WIDTH-1:4]) | (|PADDR[1:0]);
    assign reg_sel  = PADDR[3:2];
    assign wr_ok    = apb_acc & PWRITE & ~addr_bad;
    assign rd_ok    = apb_acc & ~PWRITE & ~addr_bad;

    assign start_wr = wr_ok & (reg_sel == RegCtrl) & PWDATA[0] & ~PWDATA[1];
    assign abort_wr = wr_ok & (reg_sel == RegCtrl) & PWDATA[1];

    assign busy   = (state_q == S_ISSUE) | (state_q == S_DRAIN);
    assign len_ok = (len_q != 9'd0) & (len_q <= 9'd256);

    assign acc_req_o = (state_q == S_ISSUE)
                     & (issued_q < len_q)
                     & (outst_q < MaxOutst);
    assign acc_idx_o = base_q + issued_q[7:0];

    assign grant  = acc_req_o & acc_gnt_i;
    assign rv_ok  = acc_rvalid_i & (outst_q != 4'd0);
    assign rv_bad = acc_rvalid_i & (outst_q == 4'd0);

    assign irq_o  = done_q & irq_en_q;
    assign PREADY = 1'b1;

    always_comb begin
        PRDATA  = 32'd0;
        PSLVERR = rst_n & apb_acc & addr_bad;
        if (rd_ok) begin
            unique case (reg_sel)
                RegCtrl:  PRDATA = 32'd0;
                RegCfg:   PRDATA = {irq_en_q, 14'd0, len_q, base_q};
                RegStat:  PRDATA = {29'd0, err_q, done_q, busy};
                RegCount: PRDATA = {23'd0, count_q};
                default:  PRDATA = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        abort_d  = abort_q;
        launch   = 1'b0;
        done_set = 1'b0;
        err_set  = rv_bad;
        done_clr = wr_ok & (reg_sel == RegStat) & PWDATA[1];
        err_clr  = wr_ok & (reg_sel == RegStat) & PWDATA[2];

        issued_d = issued_q + 9'(grant);
        outst_d  = outst_q + 4'(grant) - 4'(rv_ok);
        count_d  = count_q + 9'(rv_ok);

        if (wr_ok && (reg_sel == RegCfg) && !busy) begin
            base_d   = PWDATA[7:0];
            len_d    = PWDATA[16:8];
            irq_en_d = PWDATA[31];
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_wr) begin
                    if (len_ok) begin
                        launch   = 1'b1;
                        abort_d  = 1'b0;
                        state_d  = S_ISSUE;
                        issued_d = 9'd0;
                        count_d  = 9'd0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (start_wr) begin
                    err_set = 1'b1;
                end
                if (abort_wr) begin
                    abort_d = 1'b1;
                    state_d = S_DRAIN;
                end else if (issued_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (start_wr) begin
                    err_set = 1'b1;
                end
                // An aborted run ends when nothing is left in flight.
                if (abort_q) begin
                    if (outst_q == 4'd0) begin
                        abort_d = 1'b0;
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (abort_wr) begin
                    abort_d = 1'b1;
                end else if (count_q == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_set = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = launch ? 1'b0 : (done_set | (done_q & ~done_clr));
        err_d  = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= 8'd0;
            len_q    <= 9'd0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            count_q  <= 9'd0;
            issued_q <= 9'd0;
            outst_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: expected indices and read data are
// queued by the stimulus and consumed by a monitor on the falling edge.
module tb_acc_seq_ctrl;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } rd_exp_t;

    logic        clk;
    logic        rst_n;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        acc_req_o;
    logic [7:0]  acc_idx_o;
    logic        acc_gnt_i;
    logic        acc_rvalid_i;
    logic        irq_o;

    logic        auto_rv;
    logic        rv_force;
    logic [3:0]  pipe;
    int          checks;
    int          errors;
    int          gcnt;
    int          cyc;
    logic [7:0]  idx_q[$];
    rd_exp_t     rd_q[$];
    int          gcyc[$];

    assign acc_rvalid_i = (auto_rv & pipe[1]) | rv_force;

    acc_seq_ctrl #(.APB_ADDR_WIDTH(12), .MAX_OUTST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .acc_req_o   (acc_req_o),
        .acc_idx_o   (acc_idx_o),
        .acc_gnt_i   (acc_gnt_i),
        .acc_rvalid_i(acc_rvalid_i),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Accelerator model: response two cycles after each grant.
    initial begin
        logic g;
        pipe = 4'd0;
        forever begin
            @(negedge clk);
            g = acc_req_o & acc_gnt_i;
            @(posedge clk);
            #1;
            pipe = {pipe[2:0], g};
        end
    end

    initial begin
        logic [7:0] e;
        rd_exp_t    r;
        gcnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (acc_req_o && acc_gnt_i) begin
                    gcnt++;
                    gcyc.push_back(cyc);
                    if (idx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL grant_unexpected act=%h exp=none",
                                 acc_idx_o);
                    end else begin
                        e = idx_q.pop_front();
                        chk("acc_idx", {24'd0, acc_idx_o}, {24'd0, e});
                    end
                end
                if (PSEL && PENABLE && !PWRITE) begin
                    if (rd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL read_unexpected act=%h exp=none",
                                 PRDATA);
                    end else begin
                        r = rd_q.pop_front();
                        chk("prdata", PRDATA, r.d);
                        chk("pslverr", {31'd0, PSLVERR}, {31'd0, r.e});
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        tick(1);
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PENABLE = 1'b0;
        PADDR   = a;
        PWDATA  = d;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, input logic [31:0] d,
                          input logic e);
        rd_exp_t r;
        r.d = d;
        r.e = e;
        rd_q.push_back(r);
        tick(1);
        PSEL    = 1'b1;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PADDR   = a;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic pulse_rv();
        rv_force = 1'b1;
        tick(1);
        rv_force = 1'b0;
    endtask

    task automatic wait_irq(input int maxc, input string nm);
        int n;
        n = 0;
        while (!irq_o && n < maxc) begin
            tick(1);
            n++;
        end
        checks++;
        if (!irq_o) begin
            errors++;
            $display("FAIL %s act=no_irq exp=irq", nm);
        end
    endtask

    initial begin
        int g0;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        PADDR     = '0;
        PWDATA    = '0;
        PWRITE    = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        acc_gnt_i = 1'b0;
        auto_rv   = 1'b0;
        rv_force  = 1'b0;
        #2;
        chk("rst_req", {31'd0, acc_req_o}, 32'd0);
        chk("rst_idx", {24'd0, acc_idx_o}, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        apb_rd(12'h008, 32'h0, 1'b0);
        apb_rd(12'h00C, 32'h0, 1'b0);
        apb_rd(12'h004, 32'h0, 1'b0);
        chk("pready", {31'd0, PREADY}, 32'd1);

        // Basic run with interrupt
        acc_gnt_i = 1'b1;
        auto_rv   = 1'b1;
        apb_wr(12'h004, 32'h8000_0410);
        apb_rd(12'h004, 32'h8000_0410, 1'b0);
        for (int i = 0; i < 4; i++) idx_q.push_back(8'h10 + 8'(i));
        gcyc.delete();
        apb_wr(12'h000, 32'h1);
        wait_irq(50, "irq_basic");
        chk("irq_set", {31'd0, irq_o}, 32'd1);
        chk("basic_grants", gcyc.size(), 32'd4);
        if (gcyc.size() == 4)
            chk("basic_consec", gcyc[3] - gcyc[0], 32'd3);
        apb_rd(12'h008, 32'h2, 1'b0);
        apb_rd(12'h00C, 32'h4, 1'b0);
        apb_wr(12'h008, 32'h2);
        chk("irq_clr", {31'd0, irq_o}, 32'd0);
        apb_rd(12'h008, 32'h0, 1'b0);

        // Index wrap
        apb_wr(12'h004, 32'h8000_04FE);
        idx_q.push_back(8'hFE);
        idx_q.push_back(8'hFF);
        idx_q.push_back(8'h00);
        idx_q.push_back(8'h01);
        apb_wr(12'h000, 32'h1);
        wait_irq(50, "irq_wrap");
        apb_rd(12'h00C, 32'h4, 1'b0);
        apb_wr(12'h008, 32'h2);

        // Outstanding limit with withheld responses
        auto_rv = 1'b0;
        tick(4);
        apb_wr(12'h004, 32'h0000_1020);
        for (int i = 0; i < 16; i++) idx_q.push_back(8'h20 + 8'(i));
        g0 = gcnt;
        apb_wr(12'h000, 32'h1);
        tick(10);
        chk("limit_grants", gcnt - g0, 32'd4);
        chk("limit_req", {31'd0, acc_req_o}, 32'd0);
        apb_rd(12'h008, 32'h1, 1'b0);
        apb_wr(12'h004, 32'h8000_0305);
        apb_rd(12'h004, 32'h0000_1020, 1'b0);
        apb_wr(12'h000, 32'h1);
        apb_rd(12'h008, 32'h5, 1'b0);
        pulse_rv();
        tick(5);
        chk("limit_one_more", gcnt - g0, 32'd5);
        for (int i = 0; i < 15; i++) begin
            pulse_rv();
            tick(2);
        end
        tick(5);
        chk("limit_all", gcnt - g0, 32'd16);
        apb_rd(12'h008, 32'h6, 1'b0);
        apb_rd(12'h00C, 32'h10, 1'b0);
        apb_wr(12'h008, 32'h6);
        apb_rd(12'h008, 32'h0, 1'b0);

        // LEN boundaries
        apb_wr(12'h004, 32'h8000_0000);
        g0 = gcnt;
        apb_wr(12'h000, 32'h1);
        tick(4);
        chk("len0_grants", gcnt - g0, 32'd0);
        chk("len0_req", {31'd0, acc_req_o}, 32'd0);
        apb_rd(12'h008, 32'h4, 1'b0);
        apb_wr(12'h008, 32'h4);
        apb_wr(12'h004, 32'h8001_2C00);
        apb_wr(12'h000, 32'h1);
        tick(4);
        chk("len300_grants", gcnt - g0, 32'd0);
        apb_rd(12'h008, 32'h4, 1'b0);
        apb_wr(12'h008, 32'h4);
        auto_rv = 1'b1;
        apb_wr(12'h004, 32'h8001_0000);
        for (int i = 0; i < 256; i++) idx_q.push_back(8'(i));
        apb_wr(12'h000, 32'h1);
        wait_irq(600, "irq_len256");
        chk("len256_grants", gcnt - g0, 32'd256);
        apb_rd(12'h00C, 32'h100, 1'b0);
        apb_rd(12'h008, 32'h2, 1'b0);
        apb_wr(12'h008, 32'h2);

        // Abort with ops in flight
        auto_rv   = 1'b0;
        acc_gnt_i = 1'b0;
        tick(4);
        apb_wr(12'h004, 32'h0000_0840);
        for (int i = 0; i < 3; i++) idx_q.push_back(8'h40 + 8'(i));
        g0 = gcnt;
        apb_wr(12'h000, 32'h1);
        acc_gnt_i = 1'b1;
        tick(3);
        acc_gnt_i = 1'b0;
        pulse_rv();
        apb_wr(12'h000, 32'h2);
        acc_gnt_i = 1'b1;
        tick(2);
        chk("abort_req", {31'd0, acc_req_o}, 32'd0);
        apb_rd(12'h008, 32'h1, 1'b0);
        pulse_rv();
        tick(1);
        pulse_rv();
        tick(4);
        chk("abort_grants", gcnt - g0, 32'd3);
        apb_rd(12'h008, 32'h4, 1'b0);
        apb_rd(12'h00C, 32'h3, 1'b0);
        apb_wr(12'h008, 32'h4);
        apb_wr(12'h000, 32'h2);
        apb_rd(12'h008, 32'h0, 1'b0);
        apb_wr(12'h000, 32'h3);
        tick(4);
        chk("startabort_grants", gcnt - g0, 32'd3);
        apb_rd(12'h008, 32'h0, 1'b0);

        // Illegal addresses
        apb_rd(12'h010, 32'h0, 1'b1);
        apb_rd(12'h005, 32'h0, 1'b1);
        apb_wr(12'h014, 32'h8000_0177);
        apb_rd(12'h004, 32'h0000_0840, 1'b0);

        // Reset in the middle of an issue burst
        apb_wr(12'h004, 32'h0000_0800);
        for (int i = 0; i < 8; i++) idx_q.push_back(8'(i));
        apb_wr(12'h000, 32'h1);
        tick(8);
        chk("pre_rst_idx", {24'd0, acc_idx_o}, 32'h4);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, acc_req_o}, 32'd0);
        chk("midrst_idx", {24'd0, acc_idx_o}, 32'd0);
        chk("midrst_irq", {31'd0, irq_o}, 32'd0);
        chk("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
        idx_q.delete();
        acc_gnt_i = 1'b0;
        tick(2);
        rst_n = 1'b1;
        apb_rd(12'h004, 32'h0, 1'b0);
        apb_rd(12'h008, 32'h0, 1'b0);
        pulse_rv();
        apb_rd(12'h008, 32'h4, 1'b0);
        apb_rd(12'h00C, 32'h0, 1'b0);

        tick(2);
        chk("idx_q_empty", idx_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
